bcd_seq: RTL and testbench
==========================

Name: bcd_seq

Overview:
- Iterative, parametrised binary-to-BCD converter using double-dabble: one shift/add-3 step per clock.
- Trades latency for area against the fully unrolled combinational converter.
- Adds a valid/ready handshake on both sides and an optional two's-complement signed mode.
- Sits between counter/ALU result registers and seven-segment or UART decimal display logic.

Parameters:
- BIN_WIDTH, 8, width of the binary input (≥2).
- DIG_NUM, 3, number of BCD output digits. Must satisfy 10^DIG_NUM > max magnitude; a generate-time check calls $error otherwise.
- SIGNED_EN, 0, 1 = treat i_bin as two's complement and output sign + magnitude; 0 = unsigned.

Ports:
- i_clk  in  1  clock, all logic rising-edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  input word valid.
- o_ready  out  1  converter can accept (state IDLE).
- i_bin  in  BIN_WIDTH  binary value, sampled on accept.
- o_valid  out  1  result valid (state DONE).
- i_ready  in  1  downstream accepts result.
- o_bcd  out  4*DIG_NUM  packed BCD, digit 0 in [3:0].
- o_sign  out  1  1 = negative (SIGNED_EN=1 only, else tied 0).

Behaviour:
- Reset (i_rst high at edge): state=IDLE, o_bcd=0, o_sign=0, o_valid=0, internal shift/count regs=0. All inputs ignored while i_rst high. Reset mid-conversion discards the word with no output.
- o_ready = (state==IDLE); o_valid = (state==DONE). Both decode state directly; no combinational path from i_valid/i_ready.
- FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: at an edge with i_valid=1:
  - Load the magnitude into the bin shift reg. With SIGNED_EN=1 and i_bin[MSB]=1, load the two's-complement negation and set the sign reg. The most negative value -2^(BIN_WIDTH-1) yields magnitude 2^(BIN_WIDTH-1), which fits BIN_WIDTH unsigned bits.
  - Clear the bcd accumulator; cnt=BIN_WIDTH; go SHIFT.
- SHIFT, each cycle:
  - Every accumulator digit ≥5 gets +3.
  - Then shift {acc, bin} left by 1.
  - cnt decrements.
  - When cnt reaches 1 this cycle (last step), go DONE and register acc into o_bcd and sign into o_sign.
- DONE: o_bcd/o_sign held stable while o_valid=1. On an edge with i_ready=1, go IDLE.
- No overlap: o_ready=0 in SHIFT and DONE. i_valid there is ignored and not queued. Upstream holds the word until o_ready.
- Latency:
  - Accept at edge E; o_valid rises after edge E+BIN_WIDTH.
  - Minimum accept-to-accept spacing is BIN_WIDTH+2 cycles with i_ready tied high.
- Unused high digits (value smaller than 10^DIG_NUM) read 0. Digits are never >9.
- SIGNED_EN=1, input 0: o_sign=0 (no negative zero).
- o_bcd keeps the last result after the handshake until the next conversion completes.

Decomposition:
- Shared header bcd_defs.vh holds:
  - FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - The digit width constant BCD_DIG_W=4.
- Sub-module bcd_dabble_step: combinational, parameter DIG_NUM.
  - Inputs: acc, incoming bit. Output: corrected-and-shifted acc.
  - Does add-3 per digit then shift.
  - Instantiated once in the datapath.
- Top handles FSM, counter, sign/negation and output registers.

Test Plan:
- Unsigned 8/3, i_bin=0, i_ready=1 → o_valid after 8 cycles, o_bcd=12'h000, o_sign=0.
- Unsigned 8/3, i_bin=255 → o_bcd=12'h255 exactly 8 cycles after accept. Then i_bin=99 → 12'h099.
- SIGNED_EN=1, 8/3:
  - i_bin=8'h80 → o_sign=1, o_bcd=12'h128.
  - i_bin=8'hFF → o_sign=1, 12'h001.
  - i_bin=8'h7F → o_sign=0, 12'h127.
- Backpressure: i_ready=0 for 5 cycles in DONE → o_bcd/o_valid stable, o_ready=0. i_valid pulses during SHIFT/DONE are ignored (no extra result).
- Reset asserted at cycle 3 of SHIFT → next cycle o_valid=0, o_bcd=0, o_ready=1. A following i_bin=42 → 12'h042.
- BIN_WIDTH=16, DIG_NUM=5: 65535 → 20'h65535 after 16 cycles. Randomised 1000 back-to-back words checked against a reference model.

Source files
------------

// File: rtl/bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encodings, digit width and the digit-capacity check.
package bcd_seq_pkg;

   localparam int BCD_DIG_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // True when DIG_NUM decimal digits can hold the largest magnitude the
   // converter can produce (2^bw-1 unsigned, 2^(bw-1) in signed mode).
   function automatic bit bcd_fits(input int bw, input int dig, input int signed_en);
      logic [127:0] pow10;
      logic [127:0] max_mag;
      pow10 = 128'd1;
      for (int i = 0; i < dig; i++) begin
         pow10 = pow10 * 128'd10;
      end
      if (signed_en != 0) begin
         max_mag = 128'd1 << (bw - 1);
      end else begin
         max_mag = (128'd1 << bw) - 128'd1;
      end
      return (pow10 > max_mag);
   endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step: add 3 to every BCD digit that is 5 or more, then
// shift the accumulator left by one, taking the next binary bit into bit 0.
module bcd_dabble_step
   import bcd_seq_pkg::*;
#(
   parameter int DIG_NUM = 3
) (
   input  logic [BCD_DIG_W*DIG_NUM-1:0] acc,
   input  logic                         bit_in,
   output logic [BCD_DIG_W*DIG_NUM-1:0] acc_out
);

   localparam int ACC_W = BCD_DIG_W * DIG_NUM;

   logic [ACC_W-1:0] corr;

   // Per-digit add-3 correction followed by the one-bit shift.
   always_comb begin
      corr = '0;
      for (int d = 0; d < DIG_NUM; d++) begin
         if (acc[d*BCD_DIG_W +: BCD_DIG_W] >= 4'd5) begin
            corr[d*BCD_DIG_W +: BCD_DIG_W] = acc[d*BCD_DIG_W +: BCD_DIG_W] + 4'd3;
         end else begin
            corr[d*BCD_DIG_W +: BCD_DIG_W] = acc[d*BCD_DIG_W +: BCD_DIG_W];
         end
      end
      acc_out = {corr[ACC_W-2:0], bit_in};
   end

endmodule

// File: rtl/bcd_seq.sv
// Iterative binary-to-BCD converter, one double-dabble step per clock.
// Handshake: a word transfers on a rising edge where valid and ready are both
// high; ready/valid here decode the FSM state only, so neither output depends
// combinationally on i_valid or i_ready. Upstream must hold i_bin until o_ready.
module bcd_seq
   import bcd_seq_pkg::*;
#(
   parameter int BIN_WIDTH = 8,
   parameter int DIG_NUM   = 3,
   parameter int SIGNED_EN = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [BIN_WIDTH-1:0]         i_bin,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [BCD_DIG_W*DIG_NUM-1:0] o_bcd,
   output logic                         o_sign,
   output state_t                       o_dbg_state
);

   localparam int ACC_W = BCD_DIG_W * DIG_NUM;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   generate
      if (!bcd_fits(BIN_WIDTH, DIG_NUM, SIGNED_EN)) begin : g_cap_err
         $error("bcd_seq: DIG_NUM too small for the largest BIN_WIDTH magnitude");
      end
   endgenerate

   state_t               state_q;
   state_t               state_nxt;
   logic [BIN_WIDTH-1:0] bin_q;
   logic [ACC_W-1:0]     acc_q;
   logic [ACC_W-1:0]     acc_nxt;
   logic [CNT_W-1:0]     cnt_q;
   logic                 sign_q;
   logic [ACC_W-1:0]     bcd_q;
   logic                 sign_out_q;

   logic                 accept;
   logic                 last_step;
   logic                 in_neg;
   logic [BIN_WIDTH-1:0] in_mag;

   assign accept    = (state_q == ST_IDLE) && i_valid;
   assign last_step = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(1));

   // Negative inputs are converted to their magnitude; the most negative value
   // negates to 2^(BIN_WIDTH-1), which still fits as an unsigned word.
   assign in_neg = (SIGNED_EN != 0) && i_bin[BIN_WIDTH-1];
   assign in_mag = in_neg ? ((~i_bin) + {{(BIN_WIDTH-1){1'b0}}, 1'b1}) : i_bin;

   bcd_dabble_step #(
      .DIG_NUM (DIG_NUM)
   ) u_step (
      .acc     (acc_q),
      .bit_in  (bin_q[BIN_WIDTH-1]),
      .acc_out (acc_nxt)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state decode: IDLE -> SHIFT on accept, SHIFT -> DONE on the last
   // step, DONE -> IDLE when downstream takes the result.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:  if (i_valid)   state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_step) state_nxt = ST_DONE;
         ST_DONE:  if (i_ready)   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: load on accept, one shift/add-3 per SHIFT cycle, capture the
   // finished accumulator and sign into the output registers on the last step.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bin_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         bcd_q      <= '0;
         sign_out_q <= 1'b0;
      end else if (accept) begin
         bin_q  <= in_mag;
         acc_q  <= '0;
         cnt_q  <= CNT_W'(BIN_WIDTH);
         sign_q <= in_neg;
      end else if (state_q == ST_SHIFT) begin
         bin_q <= {bin_q[BIN_WIDTH-2:0], 1'b0};
         acc_q <= acc_nxt;
         cnt_q <= cnt_q - CNT_W'(1);
         if (last_step) begin
            bcd_q      <= acc_nxt;
            sign_out_q <= sign_q;
         end
      end
   end

   assign o_ready     = (state_q == ST_IDLE);
   assign o_valid     = (state_q == ST_DONE);
   assign o_bcd       = bcd_q;
   assign o_sign      = (SIGNED_EN != 0) ? sign_out_q : 1'b0;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bcd_seq.sv
// Bench for bcd_seq: unsigned 8/3, signed 8/3 and unsigned 16/5 instances
// driven with directed words, then 1000 random back-to-back 16-bit words.
module tb_bcd_seq;
   import bcd_seq_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // unsigned 8-bit, 3 digits
   logic        u_vin = 1'b0, u_rdy = 1'b0, u_rdy_o, u_vout, u_sign;
   logic [7:0]  u_bin = '0;
   logic [11:0] u_bcd;
   state_t      u_st;
   // signed 8-bit, 3 digits
   logic        s_vin = 1'b0, s_rdy = 1'b0, s_rdy_o, s_vout, s_sign;
   logic [7:0]  s_bin = '0;
   logic [11:0] s_bcd;
   state_t      s_st;
   // unsigned 16-bit, 5 digits
   logic        w_vin = 1'b0, w_rdy = 1'b0, w_rdy_o, w_vout, w_sign;
   logic [15:0] w_bin = '0;
   logic [19:0] w_bcd;
   state_t      w_st;

   bcd_seq #(.BIN_WIDTH(8), .DIG_NUM(3), .SIGNED_EN(0)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_valid(u_vin), .o_ready(u_rdy_o), .i_bin(u_bin),
      .o_valid(u_vout), .i_ready(u_rdy), .o_bcd(u_bcd), .o_sign(u_sign), .o_dbg_state(u_st));

   bcd_seq #(.BIN_WIDTH(8), .DIG_NUM(3), .SIGNED_EN(1)) s_dut (
      .i_clk(clk), .i_rst(rst), .i_valid(s_vin), .o_ready(s_rdy_o), .i_bin(s_bin),
      .o_valid(s_vout), .i_ready(s_rdy), .o_bcd(s_bcd), .o_sign(s_sign), .o_dbg_state(s_st));

   bcd_seq #(.BIN_WIDTH(16), .DIG_NUM(5), .SIGNED_EN(0)) w_dut (
      .i_clk(clk), .i_rst(rst), .i_valid(w_vin), .o_ready(w_rdy_o), .i_bin(w_bin),
      .o_valid(w_vout), .i_ready(w_rdy), .o_bcd(w_bcd), .o_sign(w_sign), .o_dbg_state(w_st));

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [19:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] ref_bcd(input int v);
      logic [19:0] r;
      int          x;
      r = '0;
      x = v;
      for (int d = 0; d < 5; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // ---------------- per-instance access ----------------
   function automatic logic f_vout(input int sel);
      case (sel)
         0: return u_vout;
         1: return s_vout;
         default: return w_vout;
      endcase
   endfunction

   function automatic logic f_rdy(input int sel);
      case (sel)
         0: return u_rdy_o;
         1: return s_rdy_o;
         default: return w_rdy_o;
      endcase
   endfunction

   function automatic logic [31:0] f_bcd(input int sel);
      case (sel)
         0: return 32'(u_bcd);
         1: return 32'(s_bcd);
         default: return 32'(w_bcd);
      endcase
   endfunction

   function automatic logic f_sign(input int sel);
      case (sel)
         0: return u_sign;
         1: return s_sign;
         default: return w_sign;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_in(input int sel, input logic v, input logic [15:0] b);
      case (sel)
         0: begin u_vin = v; u_bin = b[7:0]; end
         1: begin s_vin = v; s_bin = b[7:0]; end
         default: begin w_vin = v; w_bin = b; end
      endcase
   endtask

   task automatic set_rdy(input int sel, input logic r);
      case (sel)
         0: u_rdy = r;
         1: s_rdy = r;
         default: w_rdy = r;
      endcase
   endtask

   // One conversion: accept, measure latency, check result, optionally hold
   // i_ready low for `hold` cycles and toggle i_valid while busy, then release.
   task automatic do_conv(input int sel, input string tag, input logic [15:0] bin,
                          input logic [31:0] exp_bcd, input logic exp_sign,
                          input int hold, input bit noise);
      int bw;
      int k;
      bw = (sel == 2) ? 16 : 8;
      @(negedge clk);
      check({tag, " ready"}, 32'(f_rdy(sel)), 32'd1);
      set_in(sel, 1'b1, bin);
      @(negedge clk);
      set_in(sel, 1'b0, '0);
      check({tag, " busy"}, 32'(f_rdy(sel)), 32'd0);
      k = 0;
      while (!f_vout(sel) && k < 40) begin
         if (noise) set_in(sel, 1'($urandom_range(0, 1)), 16'($urandom));
         @(negedge clk);
         k++;
      end
      set_in(sel, 1'b0, '0);
      check({tag, " latency"}, 32'(k), 32'(bw));
      check({tag, " bcd"}, f_bcd(sel), exp_bcd);
      check({tag, " sign"}, 32'(f_sign(sel)), 32'(exp_sign));
      for (int h = 0; h < hold; h++) begin
         if (noise) set_in(sel, 1'($urandom_range(0, 1)), 16'($urandom));
         @(negedge clk);
         check({tag, " hold valid"}, 32'(f_vout(sel)), 32'd1);
         check({tag, " hold bcd"}, f_bcd(sel), exp_bcd);
         check({tag, " hold ready"}, 32'(f_rdy(sel)), 32'd0);
      end
      set_in(sel, 1'b0, '0);
      set_rdy(sel, 1'b1);
      @(negedge clk);
      set_rdy(sel, 1'b0);
      check({tag, " released"}, 32'(f_vout(sel)), 32'd0);
      check({tag, " idle"}, 32'(f_rdy(sel)), 32'd1);
      if (noise) begin
         repeat (3) @(negedge clk);
         check({tag, " no extra"}, 32'(f_vout(sel)), 32'd0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int rcv;
      repeat (3) @(negedge clk);
      check("rst valid", 32'(u_vout), 32'd0);
      check("rst ready", 32'(u_rdy_o), 32'd1);
      check("rst bcd", 32'(u_bcd), 32'd0);
      check("rst sign", 32'(s_sign), 32'd0);
      check("rst state", 32'(u_st), 32'(ST_IDLE));
      rst = 1'b0;

      // unsigned 8/3
      do_conv(0, "u0",   16'd0,   32'h000, 1'b0, 0, 1'b0);
      do_conv(0, "u255", 16'd255, 32'h255, 1'b0, 0, 1'b0);
      do_conv(0, "u99",  16'd99,  32'h099, 1'b0, 5, 1'b1);

      // reset during the third SHIFT cycle discards the word
      @(negedge clk);
      u_vin = 1'b1; u_bin = 8'd200;
      @(negedge clk);
      u_vin = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst valid", 32'(u_vout), 32'd0);
      check("midrst bcd", 32'(u_bcd), 32'd0);
      check("midrst ready", 32'(u_rdy_o), 32'd1);
      rst = 1'b0;
      do_conv(0, "u42", 16'd42, 32'h042, 1'b0, 0, 1'b0);

      // signed 8/3
      do_conv(1, "s80", 16'h0080, 32'h128, 1'b1, 0, 1'b0);
      do_conv(1, "sFF", 16'h00FF, 32'h001, 1'b1, 0, 1'b0);
      do_conv(1, "s7F", 16'h007F, 32'h127, 1'b0, 0, 1'b0);
      do_conv(1, "s00", 16'h0000, 32'h000, 1'b0, 0, 1'b0);
      do_conv(1, "sC3", 16'h00C3, 32'h061, 1'b1, 0, 1'b0);

      // unsigned 16/5
      do_conv(2, "w65535", 16'hFFFF, 32'h65535, 1'b0, 0, 1'b0);
      do_conv(2, "w10000", 16'd10000, 32'h10000, 1'b0, 0, 1'b0);

      // random back-to-back words, i_ready tied high
      w_rdy = 1'b1;
      rcv = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               int k;
               int v;
               k = 0;
               @(negedge clk);
               while (!w_rdy_o && k < 100) begin
                  @(negedge clk);
                  k++;
               end
               if (k >= 100) begin
                  check("rnd accept timeout", 32'd1, 32'd0);
                  break;
               end
               v = int'($urandom_range(0, 65535));
               w_vin = 1'b1;
               w_bin = 16'(v);
               exp_q.push_back(ref_bcd(v));
               @(negedge clk);
               w_vin = 1'b0;
            end
         end
         begin
            int t;
            logic [19:0] e;
            t = 0;
            while (rcv < 1000 && t < 30000) begin
               @(negedge clk);
               t++;
               if (w_vout) begin
                  if (exp_q.size() == 0) begin
                     check("rnd extra result", 32'd1, 32'd0);
                  end else begin
                     e = exp_q.pop_front();
                     check("rnd bcd", 32'(w_bcd), 32'(e));
                  end
                  rcv++;
               end
            end
         end
      join
      w_rdy = 1'b0;
      check("rnd count", 32'(rcv), 32'd1000);
      check("rnd queue empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
